// File: rtl/uart_rx_top.sv
// UART receiver: 2-flop input synchronizer, 3-sample majority vote at mid-bit,
// 8N1 / 8E1 / 8O1 frames (start, D0..D7 LSB first, optional parity, stop).
module uart_rx_top #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic                    rx_m, rx_s;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [2:0]              samp;
    logic                    samp_bit;
    logic                    par_flag;
    logic [PRESCALE_W-1:0]   half, last;
    logic                    bit_end;

    assign half     = prescale >> 1;
    assign last     = prescale - PRESCALE_W'(1);
    // >= rather than == so a prescale change mid-frame cannot strand the counter
    assign bit_end  = (edge_cnt >= last);
    assign samp_bit = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign busy     = (state != IDLE);

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    // Capture three samples around the bit centre for the majority vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp <= '0;
        end else if (state != IDLE) begin
            if (edge_cnt == half - PRESCALE_W'(1)) samp[0] <= rx_s;
            if (edge_cnt == half)                  samp[1] <= rx_s;
            if (edge_cnt == half + PRESCALE_W'(1)) samp[2] <= rx_s;
        end
    end

    // Frame FSM with counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_flag   <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            edge_cnt   <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state    <= START;
                        par_flag <= 1'b0;
                        par_err  <= 1'b0;
                        stp_err  <= 1'b0;
                    end
                end
                START: if (bit_end) begin
                    bit_cnt <= '0;
                    state   <= samp_bit ? IDLE : DATA;
                end
                DATA: if (bit_end) begin
                    shift_reg[bit_cnt] <= samp_bit;
                    if (bit_cnt == LAST_BIT)
                        state <= parity_en ? PARITY : STOP;
                    else
                        bit_cnt <= bit_cnt + BW'(1);
                end
                PARITY: if (bit_end) begin
                    if (samp_bit != (^shift_reg ^ parity_type))
                        par_flag <= 1'b1;
                    state <= STOP;
                end
                STOP: if (bit_end) begin
                    par_err <= par_flag;
                    stp_err <= ~samp_bit;
                    if (samp_bit && !par_flag) begin
                        data       <= shift_reg;
                        data_valid <= 1'b1;
                    end
                    // A start bit already on the line is taken now so that
                    // back-to-back frames keep exact bit-period spacing
                    if (samp_bit && !rx_s) begin
                        state    <= START;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        par_flag <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: frame table plus glitch, spike,
// back-to-back and mid-frame reset sequences.
module tb_uart_rx_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] data;
    logic       data_valid, par_err, stp_err, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vq_t[$];
    logic [7:0] vq_d[$];
    int s1, s2, s_dummy;

    uart_rx_top dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .parity_en(parity_en), .parity_type(parity_type),
        .data(data), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    // Log every cycle data_valid is high
    always @(negedge clk) begin
        if (data_valid) begin
            vq_t.push_back(cyc);
            vq_d.push_back(data);
        end
    end

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         pen, ptype, pflip, sbad;
        bit         exp_v;
        logic [7:0] exp_d;
        bit         exp_pe, exp_se;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; called #1 after a posedge. s = edge where flop 1 sees the start bit.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                              input bit ptype, input bit pflip, input bit sbad,
                              input int spike, output int s);
        logic [10:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        n = 9;
        if (pen) begin
            bits[9] = ^d ^ ptype ^ pflip;
            n = 10;
        end
        bits[n] = ~sbad;
        n++;
        s = cyc + 1;
        for (int k = 0; k < n; k++) begin
            rx_in = bits[k];
            if (k == spike) begin
                @(posedge clk); #1;
                rx_in = ~bits[k];
                @(posedge clk); #1;
                rx_in = bits[k];
                repeat (p - 2) @(posedge clk);
                #1;
            end else begin
                repeat (p) @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
    endtask

    initial begin
        int s, nb;
        tbl[0] = '{8'h3C, 8,  0, 0, 0, 0, 1, 8'h3C, 0, 0};
        tbl[1] = '{8'hA5, 16, 1, 0, 0, 0, 1, 8'hA5, 0, 0};
        tbl[2] = '{8'hA5, 16, 1, 0, 1, 0, 0, 8'hA5, 1, 0};
        tbl[3] = '{8'h81, 8,  0, 0, 0, 1, 0, 8'hA5, 0, 1};
        tbl[4] = '{8'h55, 8,  0, 0, 0, 0, 1, 8'h55, 0, 0};
        tbl[5] = '{8'h00, 32, 1, 1, 0, 0, 1, 8'h00, 0, 0};
        tbl[6] = '{8'hFF, 8,  1, 1, 0, 0, 1, 8'hFF, 0, 0};
        tbl[7] = '{8'h01, 16, 0, 0, 0, 0, 1, 8'h01, 0, 0};

        // Reset state
        idle(3);
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_par_err", par_err, 0);
        chk("rst_stp_err", stp_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        idle(4);

        // Table of single frames
        foreach (tbl[i]) begin
            prescale    = 6'(tbl[i].p);
            parity_en   = tbl[i].pen;
            parity_type = tbl[i].ptype;
            idle(2);
            vq_t.delete();
            vq_d.delete();
            send_frame(tbl[i].d, tbl[i].p, tbl[i].pen, tbl[i].ptype,
                       tbl[i].pflip, tbl[i].sbad, -1, s);
            idle(tbl[i].p + 4);
            nb = tbl[i].pen ? 11 : 10;
            chk($sformatf("v%0d_valid_count", i), vq_t.size(), tbl[i].exp_v ? 1 : 0);
            if (tbl[i].exp_v && vq_t.size() > 0)
                chk($sformatf("v%0d_latency", i), vq_t[0] - s, 2 + nb * tbl[i].p);
            chk($sformatf("v%0d_data", i), data, tbl[i].exp_d);
            chk($sformatf("v%0d_par_err", i), par_err, tbl[i].exp_pe);
            chk($sformatf("v%0d_stp_err", i), stp_err, tbl[i].exp_se);
            chk($sformatf("v%0d_busy", i), busy, 0);
        end

        // Start glitch: 3 clocks low at prescale 16
        prescale = 6'd16; parity_en = 1'b0;
        idle(2);
        vq_t.delete(); vq_d.delete();
        rx_in = 1'b0;
        idle(3);
        rx_in = 1'b1;
        idle(3);
        chk("glitch_busy_seen", busy, 1);
        idle(40);
        chk("glitch_valid_count", vq_t.size(), 0);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_par_err", par_err, 0);
        chk("glitch_stp_err", stp_err, 0);
        chk("glitch_data_held", data, 8'h01);

        // 1-clock spike at the start of D3 of byte 0x00
        vq_t.delete(); vq_d.delete();
        send_frame(8'h00, 16, 0, 0, 0, 0, 4, s);
        idle(20);
        chk("spike_valid_count", vq_t.size(), 1);
        chk("spike_data", data, 8'h00);

        // Back-to-back frames, prescale 32, odd parity
        prescale = 6'd32; parity_en = 1'b1; parity_type = 1'b1;
        idle(2);
        vq_t.delete(); vq_d.delete();
        send_frame(8'h00, 32, 1, 1, 0, 0, -1, s1);
        send_frame(8'hFF, 32, 1, 1, 0, 0, -1, s2);
        idle(40);
        chk("b2b_valid_count", vq_t.size(), 2);
        if (vq_t.size() == 2) begin
            chk("b2b_first_latency", vq_t[0] - s1, 2 + 11 * 32);
            chk("b2b_spacing", vq_t[1] - vq_t[0], 352);
            chk("b2b_data0", vq_d[0], 8'h00);
            chk("b2b_data1", vq_d[1], 8'hFF);
        end
        chk("b2b_errs", {par_err, stp_err}, 0);

        // Reset during D4 of 0x5A at prescale 8
        prescale = 6'd8; parity_en = 1'b0; parity_type = 1'b0;
        idle(2);
        vq_t.delete(); vq_d.delete();
        fork
            send_frame(8'h5A, 8, 0, 0, 0, 0, -1, s_dummy);
            begin
                idle(46);
                chk("rmid_busy_before", busy, 1);
                rst = 1'b0;
                #1;
                chk("rmid_data", data, 0);
                chk("rmid_valid", data_valid, 0);
                chk("rmid_busy", busy, 0);
                chk("rmid_errs", {par_err, stp_err}, 0);
            end
        join
        idle(2);
        rst = 1'b1;
        idle(20);
        chk("rmid_no_valid", vq_t.size(), 0);
        send_frame(8'h5A, 8, 0, 0, 0, 0, -1, s);
        idle(12);
        chk("rmid_rx_count", vq_t.size(), 1);
        if (vq_t.size() > 0)
            chk("rmid_rx_latency", vq_t[0] - s, 2 + 10 * 8);
        chk("rmid_rx_data", data, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
